// File: rtl/ps2_keyboard.sv
// PS/2 device-to-host receiver feeding a show-ahead scancode FIFO read by the CPU.
// Latency: ready rises the cycle after the stop-bit falling edge is seen (about 3 clocks after the pin edge).
// Backpressure: none towards the keyboard; a full FIFO drops the byte and sets sticky overflow.
module ps2_keyboard #(
    parameter int TIMEOUT    = 25000,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic       rd,
    input  logic       clr,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       perr
);

    localparam int PW    = DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic          clk_meta_q, clk_sync_q, clk_prev_q;
    logic          dat_meta_q, dat_sync_q;
    logic          fall, bit_in;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_expired;
    state_t        state_q;
    logic [2:0]    bitcnt_q;
    logic [7:0]    shift_q;
    logic          ok_q;
    logic          push, frame_bad;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, perr_q, perr_d;
    logic          do_rd, do_wr, full;

    // Bring the asynchronous pins into the core domain; idle level is high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2_dat;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign fall   = clk_prev_q & ~clk_sync_q;
    assign bit_in = dat_sync_q;

    // Idle timer: restarts on every ps2_clk fall and holds at its final value.
    always_comb begin
        tmo_d = tmo_q;
        if (fall)
            tmo_d = '0;
        else if (tmo_q != TMO_MAX)
            tmo_d = tmo_q + TW'(1);
    end

    assign tmo_expired = (tmo_q == TMO_MAX);

    // Frame FSM: steps on each ps2_clk fall; a stalled partial frame is abandoned silently.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            ok_q     <= 1'b0;
        end else if (fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!bit_in) begin
                        state_q  <= S_DATA;
                        bitcnt_q <= '0;
                    end
                end
                S_DATA: begin
                    shift_q  <= {bit_in, shift_q[7:1]};
                    bitcnt_q <= bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7)
                        state_q <= S_PARITY;
                end
                S_PARITY: begin
                    ok_q    <= ^shift_q ^ bit_in;
                    state_q <= S_STOP;
                end
                default: state_q <= S_IDLE;
            endcase
        end else if (tmo_expired && state_q != S_IDLE) begin
            state_q <= S_IDLE;
        end
    end

    // Stop-bit fall decides the frame's fate in the same cycle so the FIFO commits on the next edge.
    assign push      = fall & (state_q == S_STOP) & bit_in & ok_q;
    assign frame_bad = fall & (state_q == S_STOP) & ~(bit_in & ok_q);

    // FIFO bookkeeping: a pop on a full FIFO frees the slot the simultaneous push takes.
    always_comb begin
        full    = (count_q == FULL);
        do_rd   = rd & (count_q != '0);
        do_wr   = push & (~full | do_rd);
        wptr_d  = do_wr ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = do_rd ? rptr_q + PW'(1) : rptr_q;
        count_d = count_q;
        if (do_wr && !do_rd)
            count_d = count_q + CW'(1);
        else if (do_rd && !do_wr)
            count_d = count_q - CW'(1);
        ovf_d   = (push & full & ~rd) | (ovf_q & ~clr);
        perr_d  = frame_bad | (perr_q & ~clr);
    end

    // FIFO pointers, occupancy and sticky flags; a set beats a coincident clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            tmo_q   <= tmo_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            perr_q  <= perr_d;
        end
    end

    // Storage array; contents are masked by the occupancy count so it needs no reset.
    always_ff @(posedge clock) begin
        if (do_wr)
            mem[wptr_q] <= shift_q;
    end

    assign data     = (count_q != '0) ? mem[rptr_q] : 8'h00;
    assign ready    = (count_q != '0);
    assign overflow = ovf_q;
    assign perr     = perr_q;

endmodule

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
PS/2 keyboard receiver with a small scancode FIFO. It sits upstream of the CPU core's data input and is mapped into the I/O space by top-level decode. The host never drives the bus. The block deserialises device-to-host frames, checks parity and the stop bit, and buffers valid bytes. The CPU then pops them with a single-cycle read strobe.

Parameters:
TIMEOUT, 25000, number of clock cycles without a ps2_clk falling edge before a partial frame is abandoned (1 ms at 25 MHz).
DEPTH_LOG2, 3, log2 of the FIFO depth (default depth is 8 bytes).

Ports:
clock  input  1  system clock, 25 MHz domain of the core.
reset  input  1  asynchronous, active-high reset.
ps2_clk  input  1  raw PS2_CLK pin, asynchronous.
ps2_dat  input  1  raw PS2_DAT pin, asynchronous.
rd  input  1  pop strobe, one cycle per byte.
clr  input  1  clears the sticky flags.
data  output  8  byte at the FIFO head (show-ahead); 0 when the FIFO is empty.
ready  output  1  FIFO non-empty.
overflow  output  1  sticky: a valid byte was dropped because the FIFO was full.
perr  output  1  sticky: a frame had bad parity or a bad stop bit.

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE; read/write pointers, count, bit counter, shift register and timeout counter all clear.
  - Synchroniser flops are set to 1 (bus idle-high).
  - Outputs: data=0, ready=0, overflow=0, perr=0.
  - Reset asserted mid-frame discards the frame. The receiver resyncs on the next start bit.
- Synchronisation: two-flop synchroniser on ps2_clk and ps2_dat, plus a third flop on the clock line.
  - fall = prev_clk & ~sync_clk, a one-cycle pulse.
  - The data bit is sampled from sync_dat in the same cycle as fall.
- FSM (advances only on fall, except for timeout):
  - IDLE: fall with dat=0 goes to DATA and sets bitcnt=0. Fall with dat=1 is ignored.
  - DATA: shift = {dat, shift[7:1]} (LSB first) and bitcnt++. After the 8th bit, go to PARITY.
  - PARITY: latch the bit. ok = ^shift ^ bit must equal 1 (odd parity). Go to STOP.
  - STOP: if dat=1 and ok, issue push (one cycle). Otherwise set perr and do not push. Go to IDLE.
- Timeout:
  - The counter clears on every fall and saturates at TIMEOUT-1.
  - In any state other than IDLE, reaching TIMEOUT-1 forces IDLE and discards the partial frame. No flag is set.
- FIFO (2^DEPTH_LOG2 entries, count width DEPTH_LOG2+1, pointers wrap modulo depth):
  - push with count<depth: write at wptr, wptr++, count++.
  - push with count=depth and no rd: byte dropped, overflow<=1.
  - push and rd in the same cycle with count=depth: both occur, count unchanged, no overflow.
  - push and rd in the same cycle with 0<count<depth: both occur, count unchanged.
  - rd with count=0: ignored. rd together with push when count=0: the push is stored and the rd is ignored.
  - data = mem[rptr] when count≠0, else 0.
  - ready = (count≠0). Both outputs are derived from registered state, so they reflect a push on the cycle after it.
- Latency: ready rises 1 cycle after the STOP-bit fall is detected, which is 3 cycles after the raw pin edge.
- Sticky flags: clr clears overflow and perr. If a set and clr coincide in the same cycle, the set wins.

Test Plan:
- Single frame 0x1C: start 0, data bits 0,0,1,1,1,0,0,0, parity 0, stop 1, ps2_clk half-period 1000 cycles.
  - Then ready=1 and data=8'h1C.
  - Pulse rd: ready=0 and data=0.
- Bad parity: same frame with parity 1 -> no push, perr=1, ready=0. Pulse clr -> perr=0.
- Timeout: send start plus 4 bits, idle 30000 cycles, then send full frame 0xF0.
  - Exactly one byte appears, data=8'hF0, perr=0.
- Overflow: send 9 frames 0x01..0x09 with no rd.
  - overflow=1; eight pops return 0x01..0x08; then ready=0.
- Full FIFO with simultaneous events: fill with 8 bytes, then assert rd on the exact push cycle of a 9th frame 0x55.
  - overflow=0, count stays 8, the last popped byte is 0x55.
- Reset mid-frame: assert reset after 5 data bits, release, send 0x29.
  - Exactly one byte 0x29, flags 0.
